// File: rtl/video_timing_gen.sv
// Parametrised VGA timing generator: HS/VS/BLANK strobes, pixel coordinates and start pulses.
// Optional frame counter enabled by defining VTC_FRAME_CNT_EN.
module video_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CNT_W    = 12,
   parameter int   FCNT_W   = 16
) (
   input  logic              VGA_CLK,
   input  logic              reset_n,
   input  logic              enable,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic              visible_region,
   output logic [CNT_W-1:0]  pixel_x,
   output logic [CNT_W-1:0]  pixel_y,
   output logic              line_start,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic [CNT_W-1:0] px_q, px_d;
   logic [CNT_W-1:0] py_q, py_d;
   logic             blank_n_q, blank_n_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             ls_q, ls_d;
   logic             fs_q, fs_d;

   // Outputs are decoded from the pre-advance position, so they trail h/v by one enabled edge.
   always_comb begin
      h_d       = h_q;
      v_d       = v_q;
      px_d      = px_q;
      py_d      = py_q;
      blank_n_d = blank_n_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      ls_d      = ls_q;
      fs_d      = fs_q;
      if (enable) begin
         px_d      = h_q;
         py_d      = v_q;
         blank_n_d = (h_q < H_ACT_END) && (v_q < V_ACT_END);
         hs_d      = ((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
         vs_d      = ((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
         ls_d      = (h_q == '0);
         fs_d      = (h_q == '0) && (v_q == '0);
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         h_q       <= '0;
         v_q       <= '0;
         px_q      <= '0;
         py_q      <= '0;
         blank_n_q <= 1'b0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
         ls_q      <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         px_q      <= px_d;
         py_q      <= py_d;
         blank_n_q <= blank_n_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         ls_q      <= ls_d;
         fs_q      <= fs_d;
      end
   end

`ifdef VTC_FRAME_CNT_EN
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   // Counts on the edge that presents the last position of the frame.
   always_comb begin
      fcnt_d = fcnt_q;
      if (enable && (h_q == H_LAST) && (v_q == V_LAST)) begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign frame_count = fcnt_q;
`else
   assign frame_count = '0;
`endif

   assign pixel_x        = px_q;
   assign pixel_y        = py_q;
   assign VGA_BLANK_N    = blank_n_q;
   assign visible_region = blank_n_q;
   assign VGA_HS         = hs_q;
   assign VGA_VS         = vs_q;
   assign VGA_SYNC_N     = 1'b0;
   assign line_start     = ls_q;
   assign frame_start    = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen in an 8x6 small mode (HS active-low, VS active-high).
module tb_video_timing_gen;

   logic       VGA_CLK;
   logic       reset_n;
   logic       enable;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, visible_region;
   logic [3:0] pixel_x, pixel_y;
   logic       line_start, frame_start;
   logic [7:0] frame_count;

   int         n_checks = 0;
   int         n_fail   = 0;

   // Position model: mh/mv are the internal counters, ox/oy the position the outputs show.
   int         mh, mv, ox, oy;
   logic [7:0] mfc;

   logic [22:0] obs;
   assign obs = {pixel_x, pixel_y, VGA_BLANK_N, visible_region, VGA_HS, VGA_VS,
                 VGA_SYNC_N, line_start, frame_start, frame_count};

   localparam logic [22:0] RST_VEC = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b0, 8'd0};

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(4), .FCNT_W(8)
   ) dut (
      .VGA_CLK(VGA_CLK),
      .reset_n(reset_n),
      .enable(enable),
      .VGA_HS(VGA_HS),
      .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N(VGA_SYNC_N),
      .visible_region(visible_region),
      .pixel_x(pixel_x),
      .pixel_y(pixel_y),
      .line_start(line_start),
      .frame_start(frame_start),
      .frame_count(frame_count)
   );

   initial begin
      VGA_CLK = 1'b0;
      forever #5 VGA_CLK = ~VGA_CLK;
   end

   function automatic logic [7:0] fc_exp(input logic [7:0] m);
`ifdef VTC_FRAME_CNT_EN
      return m;
`else
      return 8'd0;
`endif
   endfunction

   // Hand-derived decode for the 8x6 mode: visible x<4,y<3; HS low at x=5,6; VS high at y=4.
   function automatic logic [22:0] exp_vec(input int x, input int y, input logic [7:0] fc);
      logic b, hs, vs, ls, fs;
      b  = (x < 4) && (y < 3);
      hs = (x == 5 || x == 6) ? 1'b0 : 1'b1;
      vs = (y == 4) ? 1'b1 : 1'b0;
      ls = (x == 0);
      fs = (x == 0) && (y == 0);
      return {4'(x), 4'(y), b, b, hs, vs, 1'b0, ls, fs, fc_exp(fc)};
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; ox = 0; oy = 0; mfc = 8'd0;
   endtask

   task automatic tick();
      @(posedge VGA_CLK);
      ox = mh;
      oy = mv;
      if (mh == 7 && mv == 5) mfc = mfc + 8'd1;
      if (mh == 7) begin
         mh = 0;
         mv = (mv == 5) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [22:0] e;
      reset_n = 1'b0;
      enable  = 1'b1;
      model_reset();
      repeat (3) @(posedge VGA_CLK);
      #1;
      n_checks++;
      if (obs !== RST_VEC) begin
         $display("FAIL reset_values got=%h exp=%h", obs, RST_VEC);
         n_fail++;
      end
      @(negedge VGA_CLK);
      reset_n = 1'b1;
      tick();
      e = exp_vec(0, 0, mfc);
      n_checks++;
      if (obs !== e) begin
         $display("FAIL first_edge got=%h exp=%h", obs, e);
         n_fail++;
      end
   endtask

   task automatic test_one_line();
      logic [22:0] e;
      for (int i = 1; i < 8; i++) begin
         tick();
         e = exp_vec(i, 0, mfc);
         n_checks++;
         if (obs !== e) begin
            $display("FAIL line_x%0d got=%h exp=%h", i, obs, e);
            n_fail++;
         end
      end
   endtask

   task automatic test_one_frame();
      logic [22:0] e;
      logic [7:0]  prev_fc;
      int          gap;
      gap = 7;
      for (int i = 0; i < 100; i++) begin
         prev_fc = frame_count;
         tick();
         gap++;
         e = exp_vec(ox, oy, mfc);
         n_checks++;
         if (obs !== e) begin
            $display("FAIL frame_pos(%0d,%0d) got=%h exp=%h", ox, oy, obs, e);
            n_fail++;
         end
         if (ox == 7 && oy == 5) begin
            n_checks++;
            if (prev_fc !== 8'd0 || frame_count !== fc_exp(8'd1)) begin
               $display("FAIL frame_count_step got=%0d->%0d exp=0->%0d",
                        prev_fc, frame_count, fc_exp(8'd1));
               n_fail++;
            end
         end
         if (frame_start === 1'b1) break;
      end
      n_checks++;
      if (gap !== 48) begin
         $display("FAIL frame_period got=%0d exp=48", gap);
         n_fail++;
      end
   endtask

   task automatic test_freeze();
      logic [22:0] e;
      bit          hit;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ox == 2 && oy == 1) begin
            hit = 1;
            break;
         end
      end
      n_checks++;
      if (!hit) begin
         $display("FAIL freeze_reach got=(%0d,%0d) exp=(2,1)", ox, oy);
         n_fail++;
      end
      enable = 1'b0;
      e = exp_vec(2, 1, mfc);
      for (int i = 0; i < 10; i++) begin
         @(posedge VGA_CLK);
         #1;
         n_checks++;
         if (obs !== e) begin
            $display("FAIL freeze_hold%0d got=%h exp=%h", i, obs, e);
            n_fail++;
         end
      end
      enable = 1'b1;
      tick();
      e = exp_vec(3, 1, mfc);
      n_checks++;
      if (obs !== e || ox != 3 || oy != 1) begin
         $display("FAIL freeze_resume got=%h exp=%h", obs, e);
         n_fail++;
      end
   endtask

   task automatic test_async_reset();
      logic [22:0] e;
      bit          hit;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ox == 6 && oy == 4) begin
            hit = 1;
            break;
         end
      end
      n_checks++;
      if (!hit) begin
         $display("FAIL areset_reach got=(%0d,%0d) exp=(6,4)", ox, oy);
         n_fail++;
      end
      e = exp_vec(6, 4, mfc);
      n_checks++;
      if (obs !== e) begin
         $display("FAIL areset_pre got=%h exp=%h", obs, e);
         n_fail++;
      end
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== RST_VEC) begin
         $display("FAIL areset_immediate got=%h exp=%h", obs, RST_VEC);
         n_fail++;
      end
      @(posedge VGA_CLK);
      #1;
      n_checks++;
      if (obs !== RST_VEC) begin
         $display("FAIL areset_held got=%h exp=%h", obs, RST_VEC);
         n_fail++;
      end
      model_reset();
      @(negedge VGA_CLK);
      reset_n = 1'b1;
      tick();
      e = exp_vec(0, 0, mfc);
      n_checks++;
      if (obs !== e) begin
         $display("FAIL areset_restart got=%h exp=%h", obs, e);
         n_fail++;
      end
   endtask

   task automatic test_multi_frame();
      logic [22:0] e;
      for (int i = 0; i < 3 * 48 - 1; i++) begin
         tick();
         e = exp_vec(ox, oy, mfc);
         n_checks++;
         if (obs !== e) begin
            $display("FAIL multi_pos(%0d,%0d) got=%h exp=%h", ox, oy, obs, e);
            n_fail++;
         end
      end
      n_checks++;
      if (frame_count !== fc_exp(8'd3)) begin
         $display("FAIL multi_frame_count got=%0d exp=%0d", frame_count, fc_exp(8'd3));
         n_fail++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      test_reset();
      test_one_line();
      test_one_frame();
      test_freeze();
      test_async_reset();
      test_multi_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
